// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the sequencer state encoding and the control-line bundle.
package pipeline_pkg;

  localparam int CNT_W_DEF = 32;
  localparam int DW_CNT_W = 16;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    IWAIT = 2'd1,
    DWAIT = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic pc_write;
    logic pc_sel_branch;
    logic ifid_write;
    logic idex_write;
    logic exmem_write;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic memwb_flush;
    logic imem_abort;
  } hz_ctl_t;

  localparam hz_ctl_t CTL_RUN = '{
    1'b1, 1'b0, 1'b1, 1'b1, 1'b1,
    1'b0, 1'b0, 1'b0, 1'b0, 1'b0
  };

  localparam hz_ctl_t CTL_RESET = '{
    1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
    1'b1, 1'b1, 1'b1, 1'b1, 1'b0
  };

  function automatic logic load_use_hit(
    input logic       mem_read,
    input logic [4:0] rd,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       uses_rt
  );
    return mem_read && (rd != REG_ZERO) &&
           ((rd == rs) || (uses_rt && (rd == rt)));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline registers.
// Enables and flushes are combinational; state and counters are registered.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int DWAIT_MAX = 255
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rd,
  input  logic             exmem_pc_src,
  input  logic             imem_req,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             pc_sel_branch,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             imem_abort,
  output logic             err_dwait_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redirect_cnt
);

  localparam logic [DW_CNT_W-1:0] DW_LAST =
    DW_CNT_W'(DWAIT_MAX - 1);

  hz_state_e state_q;
  hz_state_e state_d;
  logic      err_q;
  logic      err_d;
  hz_ctl_t   ctl;
  logic      redir;

  logic fetch_out;
  logic dstall;
  logic fwait;
  logic lu;
  logic dw_clr;
  logic dw_inc;
  logic [DW_CNT_W-1:0] dw_cnt;

  assign fetch_out = imem_req & ~imem_ready;

  assign dstall = (state_q == DWAIT) ?
                  ~dmem_ready : (dmem_req & ~dmem_ready);

  // Once in IWAIT the fetch is tracked by state, not by imem_req.
  assign fwait = (state_q == IWAIT) ? ~imem_ready : fetch_out;

  assign lu = load_use_hit(idex_mem_read, idex_rd,
                           ifid_rs, ifid_rt, ifid_uses_rt);

  always_comb begin
    ctl     = CTL_RUN;
    state_d = state_q;
    redir   = 1'b0;
    priority case (1'b1)
      dstall: begin
        ctl.pc_write    = 1'b0;
        ctl.ifid_write  = 1'b0;
        ctl.idex_write  = 1'b0;
        ctl.exmem_write = 1'b0;
        ctl.memwb_flush = 1'b1;
        state_d         = DWAIT;
      end
      exmem_pc_src: begin
        ctl.pc_sel_branch = 1'b1;
        ctl.ifid_flush    = 1'b1;
        ctl.idex_flush    = 1'b1;
        ctl.exmem_flush   = 1'b1;
        ctl.imem_abort    = (state_q == IWAIT) | fetch_out;
        redir             = 1'b1;
        state_d           = RUN;
      end
      default: begin
        if (lu) begin
          ctl.pc_write   = 1'b0;
          ctl.ifid_write = 1'b0;
          ctl.idex_flush = 1'b1;
        end else if (fwait) begin
          ctl.pc_write   = 1'b0;
          ctl.ifid_flush = 1'b1;
        end
        state_d = fwait ? IWAIT : RUN;
      end
    endcase
    if (!reset_n) begin
      ctl   = CTL_RESET;
      redir = 1'b0;
    end
  end

  assign dw_clr = dstall & (state_q != DWAIT);
  assign dw_inc = (state_q == DWAIT) & ~dmem_ready;
  assign err_d  = err_q | (dw_inc & (dw_cnt == DW_LAST));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (1'b0),
    .inc     (~ctl.pc_write & reset_n),
    .cnt     (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_redirect_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (1'b0),
    .inc     (redir),
    .cnt     (redirect_cnt)
  );

  sat_counter #(.W(DW_CNT_W)) u_dwait_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (dw_clr),
    .inc     (dw_inc),
    .cnt     (dw_cnt)
  );

  assign pc_write          = ctl.pc_write;
  assign pc_sel_branch     = ctl.pc_sel_branch;
  assign ifid_write        = ctl.ifid_write;
  assign idex_write        = ctl.idex_write;
  assign exmem_write       = ctl.exmem_write;
  assign ifid_flush        = ctl.ifid_flush;
  assign idex_flush        = ctl.idex_flush;
  assign exmem_flush       = ctl.exmem_flush;
  assign memwb_flush       = ctl.memwb_flush;
  assign imem_abort        = ctl.imem_abort;
  assign err_dwait_timeout = err_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline: drives write-enables and flush lines of pc, if_id, id_ex, ex_mem, mem_wb.
- Resolves load-use hazards, taken-branch redirects (resolved at EX/MEM) and multi-cycle instruction/data memory waits.
- Keeps saturating stall/redirect counters and a data-wait watchdog.
- Sits beside the pipeline registers; the flip-flop modules only consume its enable/flush outputs.

Parameters:
- CNT_W, 32, width of performance counters.
- DWAIT_MAX, 255, data-wait cycles before err_dwait_timeout sets (1..2^16-1).

Ports:
- clock  in  1  pipeline clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ifid_rs  in  5  rs of instruction in ID.
- ifid_rt  in  5  rt of instruction in ID.
- ifid_uses_rt  in  1  ID instruction reads rt.
- idex_mem_read  in  1  instruction in EX is a load.
- idex_rd  in  5  load destination in EX.
- exmem_pc_src  in  1  taken branch/jump resolved in MEM stage.
- imem_req  in  1  fetch request this cycle.
- imem_ready  in  1  fetch data valid.
- dmem_req  in  1  MEM-stage load/store access.
- dmem_ready  in  1  data access complete.
- pc_write  out  1  pc register update enable.
- pc_sel_branch  out  1  pc takes ex_mem branch target.
- ifid_write, idex_write, exmem_write  out  1 each  register hold (0 = hold).
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  load bubble (control bits 0).
- imem_abort  out  1  drop outstanding fetch.
- err_dwait_timeout  out  1  sticky watchdog flag.
- stall_cnt  out  CNT_W  cycles with pc_write=0, saturating.
- redirect_cnt  out  CNT_W  applied redirects, saturating.

Behaviour:
- Enable/flush outputs are combinational from state and inputs (same-cycle stall). State, counters and flag are registered.
- reset_n low, asynchronous:
  - state=RUN, counters=0, err=0, abort=0.
  - While low: all write enables 0, all flushes 1, pc_sel_branch=0.
- Default (no event): all write enables 1, flushes 0, pc_sel_branch=0, imem_abort=0.
- States: RUN, IWAIT, DWAIT.
- Event priority within a cycle: data wait > redirect > load-use > fetch wait.
- Data wait: dmem_req & !dmem_ready in RUN or IWAIT.
  - Next state DWAIT.
  - pc_write, ifid_write, idex_write, exmem_write = 0; memwb_flush=1. Redirect and load-use are ignored this cycle.
  - DWAIT holds these outputs while dmem_ready=0.
  - On the cycle dmem_ready=1, the remaining events are evaluated normally; next state is RUN, or IWAIT if a fetch is still pending.
- Watchdog: DWAIT cycle counter resets on DWAIT entry. Reaching DWAIT_MAX sets err_dwait_timeout, which stays set until reset. The state is unaffected.
- Redirect: exmem_pc_src=1 with no data wait.
  - pc_write=1, pc_sel_branch=1; ifid_flush, idex_flush, exmem_flush = 1.
  - redirect_cnt +1.
  - If in IWAIT, or a fetch is outstanding (imem_req & !imem_ready): imem_abort=1 for this cycle, next state RUN.
- Load-use: idex_mem_read & idex_rd!=0 & (idex_rd==ifid_rs | (ifid_uses_rt & idex_rd==ifid_rt)).
  - pc_write=0, ifid_write=0, idex_flush=1.
  - Exactly one bubble. The following cycle the load is in MEM, so the condition is naturally false.
- Fetch wait: imem_req & !imem_ready in RUN.
  - Next state IWAIT; pc_write=0, ifid_flush=1; back end keeps advancing.
  - IWAIT holds these outputs until imem_ready=1. That cycle pc_write=1, ifid_flush=0, next state RUN.
  - A load-use in the same cycle as a fetch wait takes priority on ifid: ifid_write=0, ifid_flush=0, idex_flush=1.
- stall_cnt +1 every cycle pc_write=0 after reset release.
- Both counters saturate at all-ones; no wrap.
- Simultaneous dmem_ready=1 and exmem_pc_src=1 in DWAIT: exit DWAIT and apply the redirect in that same cycle.

Decomposition:
- Shared package pipeline_pkg holds:
  - state encoding (RUN=2'd0, IWAIT=2'd1, DWAIT=2'd2);
  - REG_ZERO=5'd0;
  - default CNT_W.
- One sub-module, sat_counter (param width, inc, clear, async active-low reset), instantiated for stall_cnt, redirect_cnt and the DWAIT cycle counter.

Test Plan:
- Load-use: idex_mem_read=1, idex_rd=8, ifid_rs=8 → one cycle pc_write=0, ifid_write=0, idex_flush=1; then defaults; stall_cnt=1.
- Load to r0: idex_rd=0 matching ifid_rs=0 → no stall; stall_cnt stays 0.
- Redirect during fetch wait: imem_ready=0 for 2 cycles, then exmem_pc_src=1 → imem_abort=1, pc_sel_branch=1, three flushes=1, state RUN, redirect_cnt=1.
- Data wait with concurrent redirect:
  - dmem_ready=0 for 4 cycles with exmem_pc_src=1 → all writes 0 and memwb_flush=1 for 4 cycles, no redirect.
  - Cycle 5, dmem_ready=1 → redirect applied; stall_cnt=4.
- Watchdog: DWAIT_MAX=3, dmem_ready held 0 for 5 cycles → err_dwait_timeout rises on the cycle the counter hits 3 and stays 1 after dmem_ready=1.
- Reset mid-DWAIT: assert reset_n=0 asynchronously → flushes=1 immediately, counters=0, err=0; after release, defaults with state RUN.
